// File: rtl/serial_adder_unit_if.sv
// Operand and result handshake bundle for the bit-serial adder.
// master drives operands and consumes results; slave is the adder.
interface serial_adder_unit_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid,
        output a,
        output b,
        output cin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  cout
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  cin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output cout
    );
endinterface

// File: rtl/serial_adder_unit.sv
// Bit-serial adder: one full-adder cell reused over WIDTH cycles,
// operands shifted LSB-first with a registered carry.
module serial_adder_unit #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_unit_if.slave  bus,
    output logic                busy
);
    localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic             ov_q;
    logic [CW-1:0]    cnt;

    logic             s;
    logic             maj;
    logic [WIDTH-1:0] sum_nxt;

    assign s       = a_sh[0] ^ b_sh[0] ^ carry;
    assign maj     = (a_sh[0] & b_sh[0]) |
                     (a_sh[0] & carry) |
                     (b_sh[0] & carry);
    assign sum_nxt = {s, sum_sh[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            ov_q   <= 1'b0;
            cnt    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh  <= bus.a;
                        b_sh  <= bus.b;
                        carry <= bus.cin;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    carry  <= maj;
                    sum_sh <= sum_nxt;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + 1'b1;
                    // Final bit: publish the result as DONE is entered.
                    if (cnt == LAST) begin
                        state  <= DONE;
                        sum_q  <= sum_nxt;
                        cout_q <= maj;
                        ov_q   <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                        ov_q  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    ov_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = ov_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign busy          = (state != IDLE);
endmodule

// File: tb/tb_serial_adder_unit.sv
// Directed bench for serial_adder_unit: latency, carries, backpressure,
// asynchronous reset and back-to-back random operands.
module tb_serial_adder_unit;
    logic clk;
    logic rst;
    logic busy;
    int   n_checks;
    int   n_fail;
    int   cycle;

    serial_adder_unit_if #(.WIDTH(8)) bus ();

    serial_adder_unit #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for out_valid, sampling on falling edges.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Called on a falling edge with the unit idle and out_ready high.
    task automatic run_op(input string tag, input logic [7:0] a,
                          input logic [7:0] b, input logic ci,
                          input logic [7:0] es, input logic ec);
        int cyc;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = ci;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, ".busy"}, 32'(busy), 32'd1);
        wait_valid(cyc);
        check({tag, ".lat"}, 32'(cyc), 32'd8);
        check({tag, ".sum"}, 32'(bus.sum), 32'(es));
        check({tag, ".cout"}, 32'(bus.cout), 32'(ec));
        @(negedge clk);
        check({tag, ".ov_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".rdy"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int cyc;
        int last_acc;
        int acc;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [8:0] exp9;

        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.cin      = 1'b0;
        bus.out_ready = 1'b1;
        #3;
        check("rst.ov", 32'(bus.out_valid), 32'd0);
        check("rst.sum", 32'(bus.sum), 32'd0);
        check("rst.cout", 32'(bus.cout), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.rdy", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        run_op("ripple", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op("cin", 8'h3C, 8'h42, 1'b1, 8'h7F, 1'b0);

        // Backpressure with a pending operand that must not be taken.
        bus.out_ready = 1'b0;
        bus.a        = 8'h80;
        bus.b        = 8'h80;
        bus.cin      = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.a   = 8'h11;
        bus.b   = 8'h22;
        bus.cin = 1'b0;
        wait_valid(cyc);
        check("bp.lat", 32'(cyc), 32'd8);
        for (int i = 0; i < 5; i++) begin
            check("bp.ov", 32'(bus.out_valid), 32'd1);
            check("bp.sum", 32'(bus.sum), 32'h01);
            check("bp.cout", 32'(bus.cout), 32'd1);
            check("bp.rdy", 32'(bus.in_ready), 32'd0);
            check("bp.busy", 32'(busy), 32'd1);
            if (i < 4) @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp.idle", 32'(bus.in_ready), 32'd1);
        check("bp.ov_drop", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp.acc", 32'(busy), 32'd1);
        wait_valid(cyc);
        check("bp.lat2", 32'(cyc), 32'd8);
        check("bp.sum2", 32'(bus.sum), 32'h33);
        check("bp.cout2", 32'(bus.cout), 32'd0);
        @(negedge clk);

        // Asynchronous reset three cycles into an operation.
        bus.a        = 8'hAA;
        bus.b        = 8'h55;
        bus.cin      = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mrst.ov", 32'(bus.out_valid), 32'd0);
        check("mrst.sum", 32'(bus.sum), 32'd0);
        check("mrst.cout", 32'(bus.cout), 32'd0);
        check("mrst.busy", 32'(busy), 32'd0);
        check("mrst.rdy", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mrst.quiet", 32'(bus.out_valid), 32'd0);
        run_op("post", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);

        // Back-to-back: in_valid stays high, accepts every 10 cycles.
        last_acc = 0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            cyc = 0;
            while (bus.in_ready !== 1'b1 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            bus.a   = ra;
            bus.b   = rb;
            bus.cin = rc;
            exp9 = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            acc = cycle + 1;
            if (i > 0)
                check("b2b.gap", 32'(acc - last_acc), 32'd10);
            last_acc = acc;
            @(negedge clk);
            bus.a   = ~ra;
            bus.b   = ~rb;
            bus.cin = ~rc;
            wait_valid(cyc);
            check("b2b.res", {23'd0, bus.cout, bus.sum}, {23'd0, exp9});
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
